// File: rtl/bcd_ctrl_pkg.sv
// Shared definitions for the BCD counter controller: command opcodes,
// controller state encoding and the BCD digit helper.
package bcd_ctrl_pkg;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Non-decimal nibbles are forced to zero so every stored digit stays 0..9.
  function automatic logic [3:0] bcd_sanitize(input logic [3:0] nib);
    return (nib > BCD_MAX) ? 4'd0 : nib;
  endfunction

endpackage

// File: rtl/bcd_counter_ctrl_digit.sv
// One mod-10 BCD digit. Load has priority over increment; carry_out fires
// when this digit is incremented from 9 so the next digit advances on the
// same edge.
module bcd_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_en,
  input  logic       load_en,
  input  logic [3:0] load_val,
  output logic [3:0] value,
  output logic       carry_out
);
  import bcd_ctrl_pkg::*;

  logic [3:0] value_q;
  logic [3:0] value_d;

  // Next digit value: load, increment with decimal rollover, or hold.
  always_comb begin
    value_d = value_q;
    if (load_en) begin
      value_d = load_val;
    end else if (inc_en) begin
      value_d = (value_q >= BCD_MAX) ? 4'd0 : value_q + 4'd1;
    end
  end

  // Digit register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) value_q <= 4'd0;
    else     value_q <= value_d;
  end

  assign value     = value_q;
  assign carry_out = inc_en & (value_q == BCD_MAX);

endmodule

// File: rtl/bcd_counter_ctrl.sv
// BCD event/time counter sequencer: command handshake, IDLE/RUN/HOLD FSM,
// count prescaler and a carry-rippled cascade of bcd_digit instances.
// Optional feature macro CMP_MATCH_EN adds cmp_value/match with auto-stop
// on a tick that lands on cmp_value.
module bcd_counter_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [4*DIGITS-1:0]   cmd_data,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  wrap
`ifdef CMP_MATCH_EN
  ,
  input  logic [4*DIGITS-1:0]   cmp_value,
  output logic                  match
`endif
);
  import bcd_ctrl_pkg::*;

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

  state_t              state_q, state_d;
  logic [15:0]         presc_q, presc_d, presc_adv;
  logic                cmd_ready_q, cmd_ready_d;
  logic                wrap_q, wrap_d;
  logic                accept;
  logic                tick;
  logic                digit_load;
  logic [4*DIGITS-1:0] load_vec;
  logic [DIGITS:0]     carry;

  // A command that arrives on a tick cycle suppresses that tick.
  assign accept   = cmd_valid & cmd_ready_q;
  assign tick     = (state_q == ST_RUN) & (presc_q == PRESC_LAST) & ~accept;
  assign carry[0] = tick;

  // Digit cascade: each digit's increment enable is the carry of the one below.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .rst       (rst),
      .inc_en    (carry[i]),
      .load_en   (digit_load),
      .load_val  (load_vec[4*i +: 4]),
      .value     (count[4*i +: 4]),
      .carry_out (carry[i+1])
    );
  end

`ifdef CMP_MATCH_EN
  logic                match_q, match_d;
  logic [4*DIGITS-1:0] count_next;

  // Value the digits will hold after this edge's tick, for the compare.
  always_comb begin
    count_next = count;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry[i]) begin
        count_next[4*i +: 4] = (count[4*i +: 4] >= BCD_MAX) ? 4'd0 : count[4*i +: 4] + 4'd1;
      end
    end
  end
`endif

  // Command decode, next state, prescaler and handshake turnaround.
  always_comb begin
    state_d     = state_q;
    presc_adv   = (presc_q == PRESC_LAST) ? 16'd0 : presc_q + 16'd1;
    presc_d     = presc_q;
    cmd_ready_d = ~accept;
    wrap_d      = tick & carry[DIGITS];
    digit_load  = 1'b0;
    load_vec    = '0;
`ifdef CMP_MATCH_EN
    match_d     = 1'b0;
`endif
    if (accept) begin
      case (cmd_op)
        OP_CLEAR: begin
          state_d    = ST_IDLE;
          presc_d    = 16'd0;
          digit_load = 1'b1;
        end
        OP_START: begin
          if (state_q != ST_RUN) begin
            state_d = ST_RUN;
            presc_d = 16'd0;
          end else begin
            presc_d = presc_adv;
          end
        end
        OP_STOP: begin
          if (state_q == ST_RUN) state_d = ST_HOLD;
        end
        OP_LOAD: begin
          digit_load = 1'b1;
          presc_d    = 16'd0;
          for (int i = 0; i < DIGITS; i++) begin
            load_vec[4*i +: 4] = bcd_sanitize(cmd_data[4*i +: 4]);
          end
          if (state_q == ST_IDLE) state_d = ST_HOLD;
        end
        default: ;
      endcase
    end else if (state_q == ST_RUN) begin
      presc_d = presc_adv;
`ifdef CMP_MATCH_EN
      if (tick && (count_next == cmp_value)) begin
        match_d = 1'b1;
        state_d = ST_HOLD;
      end
`endif
    end
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      presc_q     <= 16'd0;
      cmd_ready_q <= 1'b1;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      cmd_ready_q <= cmd_ready_d;
      wrap_q      <= wrap_d;
    end
  end

`ifdef CMP_MATCH_EN
  // Match pulse register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) match_q <= 1'b0;
    else     match_q <= match_d;
  end

  assign match = match_q;
`endif

  assign cmd_ready = cmd_ready_q;
  assign running   = (state_q == ST_RUN);
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_bcd_counter_ctrl.sv
// Bench for bcd_counter_ctrl: two instances (PRESCALE 1 and 3) share the
// command bus and are compared every cycle against an integer-valued model.
module tb_bcd_counter_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int MAXV   = 10000;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic [W-1:0] cmp_value;
  logic [W-1:0] count_o   [2];
  logic         running_o [2];
  logic         wrap_o    [2];
  logic         ready_o   [2];
  logic         match_o   [2];

  int checks   = 0;
  int failures = 0;

  int  per     [2] = '{1, 3};
  int  m_cnt   [2];
  int  m_ph    [2];
  int  m_mode  [2];
  bit  m_wrap  [2];
  bit  m_match [2];
  bit  m_ready;

  always #5 clk = ~clk;

  bcd_counter_ctrl #(.DIGITS(DIGITS), .PRESCALE(1)) u_dut_a (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready_o[0]),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .count(count_o[0]),
    .running(running_o[0]), .wrap(wrap_o[0])
`ifdef CMP_MATCH_EN
    , .cmp_value(cmp_value), .match(match_o[0])
`endif
  );

  bcd_counter_ctrl #(.DIGITS(DIGITS), .PRESCALE(3)) u_dut_b (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready_o[1]),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .count(count_o[1]),
    .running(running_o[1]), .wrap(wrap_o[1])
`ifdef CMP_MATCH_EN
    , .cmp_value(cmp_value), .match(match_o[1])
`endif
  );

`ifndef CMP_MATCH_EN
  assign match_o[0] = 1'b0;
  assign match_o[1] = 1'b0;
`endif

  // Decimal value of a loaded word; non-decimal nibbles read as 0.
  function automatic int load_to_int(input logic [W-1:0] d);
    int v = 0;
    int scale = 1;
    for (int i = 0; i < DIGITS; i++) begin
      int n = int'(d[4*i +: 4]);
      if (n > 9) n = 0;
      v += n * scale;
      scale *= 10;
    end
    return v;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      string s = (k == 0) ? "a" : "b";
      check({tag, "_count_", s},   32'(count_o[k]),   32'(int_to_bcd(m_cnt[k])));
      check({tag, "_running_", s}, 32'(running_o[k]), 32'(m_mode[k] == M_RUN));
      check({tag, "_wrap_", s},    32'(wrap_o[k]),    32'(m_wrap[k]));
      check({tag, "_ready_", s},   32'(ready_o[k]),   32'(m_ready));
`ifdef CMP_MATCH_EN
      check({tag, "_match_", s},   32'(match_o[k]),   32'(m_match[k]));
`endif
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_ph[k] = 0; m_mode[k] = M_IDLE;
      m_wrap[k] = 1'b0; m_match[k] = 1'b0;
    end
    m_ready = 1'b1;
  endtask

  // Behaviour of one rising edge, from the command/tick rules.
  task automatic model_edge(input bit v, input logic [1:0] op, input logic [W-1:0] d);
    bit acc = v && m_ready;
    for (int k = 0; k < 2; k++) begin
      m_wrap[k]  = 1'b0;
      m_match[k] = 1'b0;
      if (acc) begin
        case (op)
          2'b00: begin m_cnt[k] = 0; m_mode[k] = M_IDLE; m_ph[k] = 0; end
          2'b01: begin
            if (m_mode[k] != M_RUN) begin m_mode[k] = M_RUN; m_ph[k] = 0; end
            else m_ph[k] = (m_ph[k] + 1) % per[k];
          end
          2'b10: if (m_mode[k] == M_RUN) m_mode[k] = M_HOLD;
          default: begin
            m_cnt[k] = load_to_int(d);
            m_ph[k]  = 0;
            if (m_mode[k] == M_IDLE) m_mode[k] = M_HOLD;
          end
        endcase
      end else if (m_mode[k] == M_RUN) begin
        if (m_ph[k] == per[k] - 1) begin
          m_ph[k] = 0;
          if (m_cnt[k] == MAXV - 1) m_wrap[k] = 1'b1;
          m_cnt[k] = (m_cnt[k] + 1) % MAXV;
`ifdef CMP_MATCH_EN
          if (int_to_bcd(m_cnt[k]) == cmp_value) begin
            m_match[k] = 1'b1;
            m_mode[k]  = M_HOLD;
          end
`endif
        end else begin
          m_ph[k] = m_ph[k] + 1;
        end
      end
    end
    m_ready = !acc;
  endtask

  task automatic step(input bit v, input logic [1:0] op, input logic [W-1:0] d, input string tag);
    cmd_valid = v; cmd_op = op; cmd_data = d;
    @(posedge clk);
    model_edge(v, op, d);
    #1;
    cmd_valid = 1'b0;
    check_all(tag);
  endtask

  task automatic cmd(input logic [1:0] op, input logic [W-1:0] d, input string tag);
    if (!m_ready) step(1'b0, 2'b00, '0, {tag, "_turn"});
    step(1'b1, op, d, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, '0, tag);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = '0;
    cmp_value = {W{1'b1}};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check("reset_count_const", 32'(count_o[0]), 32'h0);
    check("reset_ready_const", 32'(ready_o[0]), 32'h1);
    rst = 1'b0;
    idle(1, "post_reset");

    // Plain counting with carries.
    cmd(2'b01, '0, "start");
    idle(10, "run10");
    check("cnt_0010", 32'(count_o[0]), 32'h0010);
    check("cnt_p3_0003", 32'(count_o[1]), 32'h0003);
    idle(90, "run100");
    check("cnt_0100", 32'(count_o[0]), 32'h0100);
    check("cnt_p3_0033", 32'(count_o[1]), 32'h0033);

    // Full-scale wrap.
    cmd(2'b00, '0, "clear");
    cmd(2'b11, 16'h9998, "load9998");
    cmd(2'b01, '0, "start_wrap");
    step(1'b0, 2'b00, '0, "to9999");
    check("cnt_9999", 32'(count_o[0]), 32'h9999);
    step(1'b0, 2'b00, '0, "to0000");
    check("cnt_0000", 32'(count_o[0]), 32'h0000);
    check("wrap_pulse", 32'(wrap_o[0]), 32'h1);
    step(1'b0, 2'b00, '0, "to0001");
    check("cnt_0001", 32'(count_o[0]), 32'h0001);
    check("wrap_drop", 32'(wrap_o[0]), 32'h0);
    idle(4, "post_wrap");

    // Stop, hold, resume.
    cmd(2'b10, '0, "stop");
    check("stopped", 32'(running_o[1]), 32'h0);
    idle(5, "hold");
    cmd(2'b01, '0, "resume");
    idle(7, "resumed");

    // Load sanitation and command-over-tick priority.
    cmd(2'b11, 16'h12F4, "load12F4");
    check("cnt_1204", 32'(count_o[0]), 32'h1204);
    check("ready_turn", 32'(ready_o[0]), 32'h0);
    step(1'b0, 2'b00, '0, "to1205");
    check("cnt_1205", 32'(count_o[0]), 32'h1205);
    cmd(2'b01, '0, "start_on_tick");
    check("tick_dropped", 32'(count_o[0]), 32'h1205);

    // Asynchronous reset mid-run.
    cmd(2'b11, 16'h0457, "load0457");
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_rst_count", 32'(count_o[0]), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1, "rst_release");

`ifdef CMP_MATCH_EN
    // Compare match with auto-stop.
    cmp_value = 16'h0005;
    cmd(2'b01, '0, "start_cmp");
    idle(8, "cmp_run");
    check("cmp_cnt_0005", 32'(count_o[0]), 32'h0005);
    check("cmp_stopped", 32'(running_o[0]), 32'h0);
    idle(10, "cmp_run_b");
    cmp_value = {W{1'b1}};
`endif

    // Randomized command traffic.
    for (int n = 0; n < 600; n++) begin
      int r = int'($urandom % 16);
      bit v = ($urandom % 3) != 0;
      logic [1:0] op;
      logic [W-1:0] d = W'($urandom);
      if (r < 7)       op = 2'b01;
      else if (r < 10) op = 2'b10;
      else if (r < 13) op = 2'b11;
      else             op = 2'b00;
      if ($urandom % 2 == 1) d = 16'h9990 | W'($urandom % 16);
`ifdef CMP_MATCH_EN
      if ($urandom % 50 == 0) cmp_value = int_to_bcd(int'($urandom % MAXV));
`endif
      step(v, op, d, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
